// File: rtl/jtopl_mmr_bank.sv
// jtopl_mmr_bank: OPL2/OPL3 CPU register front-end with busy window, drop counter,
// timer controls and per-channel update strobes.
module jtopl_mmr_bank #(
  parameter int CH       = 18,
  parameter int BANKS    = 2,
  parameter int BUSY_CYC = 4,
  parameter int CHW      = 5
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_cenop,
  input  logic [7:0]     i_din,
  input  logic [1:0]     i_addr,
  input  logic           i_write,
  output logic           o_busy,
  output logic [7:0]     o_drop_cnt,
  output logic [7:0]     o_value_A,
  output logic [7:0]     o_value_B,
  output logic           o_load_A,
  output logic           o_load_B,
  output logic           o_flagen_A,
  output logic           o_flagen_B,
  output logic           o_clr_flag_A,
  output logic           o_clr_flag_B,
  output logic           o_opl3_en,
  output logic [5:0]     o_conn4op,
  output logic [7:0]     o_din_copy,
  output logic [4:0]     o_latch_fnum,
  output logic [CHW-1:0] o_up_ch,
  output logic           o_up_fnum,
  output logic           o_up_fbcon
);
  localparam int BW = $clog2(BUSY_CYC + 1);
  logic [7:0]    r_selreg;
  logic          r_selbank;
  logic [BW-1:0] r_busy_cnt;
  logic          w_data, w_acc, w_drop, w_dec, w_b0, w_b1, w_chok, w_ax, w_bx, w_cx, w_clr;
  logic [4:0]    w_ch;
  assign o_busy = r_busy_cnt != '0;
  assign w_data = i_write && i_addr[0];
  assign w_acc  = w_data && !o_busy;
  assign w_drop = w_data && o_busy;
  // bank1 is locked down to reg 05 until the NEW bit is set
  assign w_dec  = w_acc && (!r_selbank || o_opl3_en || r_selreg == 8'h05);
  assign w_b0   = w_dec && !r_selbank;
  assign w_b1   = w_dec && r_selbank;
  assign w_ch   = (r_selbank ? 5'd9 : 5'd0) + {1'b0, r_selreg[3:0]};
  assign w_chok = w_dec && r_selreg[3:0] <= 4'd8 && int'(w_ch) < CH;
  assign w_ax   = w_chok && r_selreg[7:4] == 4'hA;
  assign w_bx   = w_chok && r_selreg[7:4] == 4'hB;
  assign w_cx   = w_chok && r_selreg[7:4] == 4'hC;
  assign w_clr  = w_b0 && r_selreg == 8'h04 && i_din[7];
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_selreg     <= '0;
      r_selbank    <= 1'b0;
      r_busy_cnt   <= '0;
      o_drop_cnt   <= '0;
      o_value_A    <= '0;
      o_value_B    <= '0;
      o_load_A     <= 1'b0;
      o_load_B     <= 1'b0;
      o_flagen_A   <= 1'b1;
      o_flagen_B   <= 1'b1;
      o_clr_flag_A <= 1'b0;
      o_clr_flag_B <= 1'b0;
      o_opl3_en    <= 1'b0;
      o_conn4op    <= '0;
      o_din_copy   <= '0;
      o_latch_fnum <= '0;
      o_up_ch      <= '0;
      o_up_fnum    <= 1'b0;
      o_up_fbcon   <= 1'b0;
    end else begin
      if (i_write && !i_addr[0]) begin
        r_selreg  <= i_din;
        r_selbank <= i_addr[1] && (BANKS == 2);
      end
      if (w_drop && o_drop_cnt != 8'hFF) o_drop_cnt <= o_drop_cnt + 8'd1;
      if (w_acc) begin
        r_busy_cnt   <= BW'(BUSY_CYC);
        o_din_copy   <= i_din;
        o_up_fnum    <= w_ax;
        o_up_fbcon   <= w_cx;
        o_clr_flag_A <= w_clr;
        o_clr_flag_B <= w_clr;
        if (w_ax || w_cx) o_up_ch <= CHW'(w_ch);
        if (w_bx) o_latch_fnum <= i_din[4:0];
        if (w_b0 && r_selreg == 8'h02) o_value_A <= i_din;
        if (w_b0 && r_selreg == 8'h03) o_value_B <= i_din;
        if (w_b0 && r_selreg == 8'h04) begin
          o_flagen_A <= !i_din[6];
          o_flagen_B <= !i_din[5];
          o_load_A   <= i_din[0];
          o_load_B   <= i_din[1];
        end
        if (w_b1 && r_selreg == 8'h04) o_conn4op <= i_din[5:0];
        if (w_b1 && r_selreg == 8'h05) o_opl3_en <= i_din[0];
      end else if (i_cenop) begin
        o_up_fnum    <= 1'b0;
        o_up_fbcon   <= 1'b0;
        o_clr_flag_A <= 1'b0;
        o_clr_flag_B <= 1'b0;
        if (o_busy) r_busy_cnt <= r_busy_cnt - BW'(1);
      end
    end
  end
endmodule
